line_mem_responder: RTL and testbench
=====================================

// Module: line_mem_responder
// PURPOSE
//  Memory-side responder for the cache's 128-bit line interface (mem_read/mem_write/mem_address/
//  mem_wdata -> mem_rdata/mem_resp). Holds a line-organised backing store and answers each cache
//  line fill or writeback with a programmable fixed latency. Sits below the cache datapath/control
//  pair as the synthesizable physical-memory model for integration and FPGA builds.
// PARAMETERS
//  INDEX_WIDTH  8  line-index bits taken from mem_address[INDEX_WIDTH+3:4]; store = 2**INDEX_WIDTH lines
//  LATENCY      4  cycles from request acceptance to mem_resp; legal range 1..255
// PORTS
//  clk              in   1    clock; all state updates on rising edge
//  reset_n          in   1    asynchronous, active-low reset
//  mem_read         in   1    line read request; held until mem_resp
//  mem_write        in   1    line write request; held until mem_resp
//  mem_address      in   16   byte address; [3:0] ignored, bits above INDEX_WIDTH+3 ignored (alias)
//  mem_byte_enable  in   2    accepted for interface compatibility; ignored (full-line transfers only)
//  mem_wdata        in   128  writeback line
//  mem_rdata        out  128  fill line; valid while mem_resp=1, held until the next read response
//  mem_resp         out  1    one-cycle completion strobe
//  proto_err        out  1    sticky protocol-violation flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync-released use): state=IDLE, cnt=0, mem_resp=0, mem_rdata=0, proto_err=0.
//    Store contents are NOT reset; reads of never-written lines return undefined data.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: on edge with mem_read|mem_write=1, capture op, index, wdata into registers; cnt=LATENCY-1;
//          go BUSY (LATENCY>1) or RESP (LATENCY=1). No request: stay IDLE.
//    BUSY: cnt decrements each edge; at cnt==1 go RESP. Inputs not re-sampled.
//    RESP: mem_resp=1 for exactly this cycle; next state IDLE unconditionally.
//  - Latency: request sampled at edge k -> mem_resp high in the cycle after edge k+LATENCY-1,
//    i.e. LATENCY cycles after acceptance. Back-to-back: a new request present in the cycle after
//    RESP is accepted at that cycle's edge (no extra turnaround).
//  - Commit: write updates store[index] with captured wdata on the edge entering RESP; read loads
//    mem_rdata from store[index] on the same edge (registered output). A read issued right after
//    a write to the same line returns the new data.
//  - mem_read and mem_write both 1 at acceptance: treated as write; mem_rdata unchanged.
//  - Write responses do not modify mem_rdata.
//  - Request dropped or changed during BUSY: ignored; the captured transaction completes and
//    mem_resp still pulses.
//  - Reset mid-transaction: transaction aborted; if asserted before the commit edge, the store is
//    unchanged; mem_resp never pulses for the aborted request.
// CONFIGURATION
//  LINE_MEM_PROTO_CHECK_EN defined: proto_err is set (sticky until reset) when
//    (a) mem_read&mem_write at acceptance,
//    (b) in BUSY/RESP the request is deasserted, or mem_address[15:4] or mem_wdata (writes)
//        differs from the captured value,
//    (c) mem_byte_enable!=2'b11 at acceptance.
//    Detection is registered: proto_err rises on the edge after the violating cycle.
//  Not defined: proto_err tied to 0; no checker logic synthesized. Functional behaviour is
//    identical either way.
// TESTING
//  1 Reset: hold reset_n=0 -> mem_resp=0, mem_rdata=0, proto_err=0; release, idle 5 cycles -> no resp.
//  2 Write 0xA..A5 at 0x0120, then read 0x0120 (LATENCY=4) -> resp exactly 4 cycles after each
//    acceptance; read returns 0xA..A5.
//  3 Aliasing/offset: write 0x1234..1234 at 0x0130, then read 0x013F and (INDEX_WIDTH=8) 0x1130
//    -> both return 0x1234..1234.
//  4 Back-to-back writeback then fill: write line X to 0x0200; assert read 0x0300 the cycle after
//    resp -> second resp 4 cycles later; 0x0200 holds X.
//  5 Reset mid-write: accept write 0xFF..FF to 0x0040 (old 0x0), pulse reset_n at cycle 2
//    -> no resp; read 0x0040 returns 0x0.
//  6 With LINE_MEM_PROTO_CHECK_EN: assert read+write together -> write performed, proto_err=1 and
//    stays 1; without the macro, the same stimulus leaves proto_err=0.

Source files
------------

// File: rtl/line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : line_mem_responder
// Description : Memory-side responder for a 128-bit cache line interface.
//               Holds a line-organised backing store and answers each line
//               fill (read) or writeback (write) after a fixed LATENCY.
//               Sequence per request: IDLE -> BUSY -> RESP -> IDLE.
// Ports       : clk             - clock, rising-edge
//               reset_n         - asynchronous active-low reset
//               mem_read        - line read request, held until mem_resp
//               mem_write       - line write request, held until mem_resp
//               mem_address     - byte address, line index in
//                                 [INDEX_WIDTH+3:4]
//               mem_byte_enable - accepted but unused (full-line transfers)
//               mem_wdata       - writeback line
//               mem_rdata       - fill line, held until the next read
//               mem_resp        - one-cycle completion strobe
//               proto_err       - sticky protocol-violation flag
// Build macro : LINE_MEM_PROTO_CHECK_EN enables the protocol checker that
//               drives proto_err; without it proto_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder #(
    parameter int INDEX_WIDTH = 8,
    parameter int LATENCY     = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [1:0]   mem_byte_enable,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         proto_err
);

    localparam int        c_LINES    = 2 ** INDEX_WIDTH;
    localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_cnt;
    logic                     r_op_write;
    logic [INDEX_WIDTH-1:0]   r_index;
    logic [127:0]             r_wdata;
    logic [127:0]             r_rdata;
    logic [127:0]             r_store [0:c_LINES-1];

    logic                     w_req;
    logic                     w_accept;
    logic                     w_commit;
    logic                     w_commit_write;
    logic [INDEX_WIDTH-1:0]   w_commit_idx;
    logic [127:0]             w_commit_data;
    logic [INDEX_WIDTH-1:0]   w_idx_in;
    logic                     w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_idx_in = mem_address[INDEX_WIDTH+3:4];

    // Byte enables and the aliased/offset address bits carry no function.
    assign w_unused = ^{mem_byte_enable, mem_address};

    // ------------------------------------------------------------------
    // Next-state logic. The commit strobe marks the edge that enters RESP:
    // the store write and the registered fill both happen on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = ST_RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == 8'd1) begin
                    w_state_nxt = ST_RESP;
                    w_commit    = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // With LATENCY=1 the commit coincides with acceptance, so the live
    // inputs are used instead of the (not yet loaded) capture registers.
    // A simultaneous read+write is treated as a write.
    always_comb begin
        if (w_accept) begin
            w_commit_write = mem_write;
            w_commit_idx   = w_idx_in;
            w_commit_data  = mem_wdata;
        end else begin
            w_commit_write = r_op_write;
            w_commit_idx   = r_index;
            w_commit_data  = r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_op_write <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op_write <= mem_write;
                r_index    <= w_idx_in;
                r_wdata    <= mem_wdata;
                r_cnt      <= c_CNT_INIT;
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            // Write responses leave the last fill line untouched.
            if (w_commit && !w_commit_write) begin
                r_rdata <= r_store[w_commit_idx];
            end
        end
    end

    // Backing store: contents deliberately not reset. The reset_n term
    // keeps an aborted or in-reset request from ever committing.
    always_ff @(posedge clk) begin
        if (reset_n && w_commit && w_commit_write) begin
            r_store[w_commit_idx] <= w_commit_data;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_resp  = (r_state == ST_RESP);

`ifdef LINE_MEM_PROTO_CHECK_EN
    // ------------------------------------------------------------------
    // Protocol checker: flags a combined read+write or partial byte
    // enables at acceptance, and any drop or change of the request while
    // it is outstanding. Registered, so the flag rises one edge later.
    // ------------------------------------------------------------------
    logic [11:0] r_addr_hi;
    logic        r_proto_err;
    logic        w_violation;

    always_comb begin
        w_violation = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && ((mem_read && mem_write) || (mem_byte_enable != 2'b11))) begin
                    w_violation = 1'b1;
                end
            end
            ST_BUSY, ST_RESP: begin
                if (r_op_write ? !mem_write : !mem_read) begin
                    w_violation = 1'b1;
                end
                if (mem_address[15:4] != r_addr_hi) begin
                    w_violation = 1'b1;
                end
                if (r_op_write && (mem_wdata != r_wdata)) begin
                    w_violation = 1'b1;
                end
            end
            default: begin
                w_violation = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_hi   <= 12'd0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_hi <= mem_address[15:4];
            end
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign proto_err = r_proto_err;
`else
    assign proto_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Self-checking bench for line_mem_responder. A line-level
//               model (associative store, pending-response record) predicts
//               mem_resp / mem_rdata / proto_err every cycle; directed
//               scenarios add literal expectations, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    localparam int LAT = 4;
    localparam int IW  = 8;
`ifdef LINE_MEM_PROTO_CHECK_EN
    localparam bit PROTO_EXP = 1'b1;
`else
    localparam bit PROTO_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [15:0]  mem_address = 16'd0;
    logic [1:0]   mem_byte_enable = 2'b11;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic         proto_err;

    line_mem_responder #(
        .INDEX_WIDTH (IW),
        .LATENCY     (LAT)
    ) u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_edge = 0;

    always @(posedge clk) n_edge <= n_edge + 1;

    // ---------------- behavioural model state ----------------
    logic [127:0] mstore [int];
    bit           pend = 1'b0;
    int           pend_edge;
    int           pend_acc;
    bit           pend_wr;
    bit           pend_both;
    int           pend_idx;
    logic [127:0] pend_data;
    logic [127:0] exp_rdata = '0;
    bit           rdata_known = 1'b1;
    bit           exp_proto = 1'b0;
    bit           cmp_er;

    function automatic int idx_of(input logic [15:0] a);
        return (int'(a) / 16) % (1 << IW);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            pend        = 1'b0;
            exp_rdata   = '0;
            rdata_known = 1'b1;
            exp_proto   = 1'b0;
            check("reset_resp", mem_resp, 1'b0);
            check("reset_rdata", mem_rdata, '0);
            check("reset_proto", proto_err, 1'b0);
        end else begin
            cmp_er = pend && (n_edge == pend_edge);
            if (PROTO_EXP && pend && pend_both && (n_edge >= pend_acc)) exp_proto = 1'b1;
            if (cmp_er) begin
                if (pend_wr) begin
                    mstore[pend_idx] = pend_data;
                end else if (mstore.exists(pend_idx)) begin
                    exp_rdata   = mstore[pend_idx];
                    rdata_known = 1'b1;
                end else begin
                    rdata_known = 1'b0;
                end
                pend = 1'b0;
            end
            check("mem_resp", mem_resp, cmp_er);
            if (rdata_known) check("mem_rdata", mem_rdata, exp_rdata);
            check("proto_err", proto_err, exp_proto);
        end
    end

    // Present a request (called at a falling edge with the DUT idle), record
    // it in the model, wait for the response, then step into the idle cycle.
    task automatic post(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [127:0] data);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = data;
        mem_byte_enable = 2'b11;
        pend_acc        = n_edge + 1;
        pend_edge       = n_edge + LAT;
        pend_wr         = wr;
        pend_both       = rd && wr;
        pend_idx        = idx_of(addr);
        pend_data       = data;
        pend            = 1'b1;
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [127:0] data, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        post(rd, wr, addr, data);
        for (int k = 1; k <= LAT + 6 && !got; k++) begin
            @(negedge clk);
            if (mem_resp) begin
                got = 1'b1;
                lat = k;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL resp_timeout actual=none required=resp within %0d cycles", LAT + 6);
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    int           lat;
    logic [127:0] line_x;
    logic [127:0] d6;

    initial begin
        // 1: reset, then quiet idle cycles (per-cycle compare expects no resp)
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_rdata_in_reset", mem_rdata, 128'h0);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_idle_noresp", mem_resp, 1'b0);

        // 2: write then read, latency measured from acceptance
        txn(1'b0, 1'b1, 16'h0120, {16{8'hA5}}, lat);
        check("t2_wr_latency", 128'(lat), 128'(4));
        txn(1'b1, 1'b0, 16'h0120, '0, lat);
        check("t2_rd_latency", 128'(lat), 128'(4));
        check("t2_rd_data", mem_rdata, {16{8'hA5}});

        // 3: offset bits and upper aliased bits are ignored
        txn(1'b0, 1'b1, 16'h0130, {8{16'h1234}}, lat);
        txn(1'b1, 1'b0, 16'h013F, '0, lat);
        check("t3_offset", mem_rdata, {8{16'h1234}});
        txn(1'b1, 1'b0, 16'h1130, '0, lat);
        check("t3_alias", mem_rdata, {8{16'h1234}});

        // 4: writeback immediately followed by a fill
        line_x = rnd128();
        txn(1'b0, 1'b1, 16'h0200, line_x, lat);
        txn(1'b1, 1'b0, 16'h0300, '0, lat);
        check("t4_b2b_latency", 128'(lat), 128'(4));
        txn(1'b1, 1'b0, 16'h0200, '0, lat);
        check("t4_line_x", mem_rdata, line_x);

        // 5: reset while a write is in flight aborts it
        txn(1'b0, 1'b1, 16'h0040, 128'h0, lat);
        post(1'b0, 1'b1, 16'h0040, {128{1'b1}});
        @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_noresp", mem_resp, 1'b0);
        txn(1'b1, 1'b0, 16'h0040, '0, lat);
        check("t5_old_data", mem_rdata, 128'h0);

        // random protocol-compliant traffic over a handful of lines
        for (int t = 0; t < 80; t++) begin
            logic [15:0] a;
            bit          rd;
            a  = {4'($urandom), 8'(($urandom % 16) * 7 + 3), 4'($urandom)};
            rd = ($urandom % 2 == 1) && mstore.exists(idx_of(a));
            txn(rd, !rd, a, rnd128(), lat);
            check("rand_latency", 128'(lat), 128'(LAT));
            repeat ($urandom % 3) @(negedge clk);
        end

        // 6: read+write together acts as a write; checker flags it
        d6 = rnd128();
        txn(1'b1, 1'b0, 16'h0200, '0, lat);
        txn(1'b1, 1'b1, 16'h0500, d6, lat);
        check("t6_rdata_unchanged", mem_rdata, line_x);
        check("t6_proto", proto_err, PROTO_EXP);
        txn(1'b1, 1'b0, 16'h0500, '0, lat);
        check("t6_written", mem_rdata, d6);
        repeat (3) @(negedge clk);
        check("t6_proto_sticky", proto_err, PROTO_EXP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
